// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution, EX/MEM register, PC redirect and
// squashing of the wrong-path slots that follow a taken branch or jump.
module ex_stage #(
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_E,
  input  logic        Jump_E,
  input  logic        Branch_E,
  input  logic        RegW_enable_E,
  input  logic        ALU_src_E,
  input  logic [3:0]  ALU_control_E,
  input  logic        Mem_Write_E,
  input  logic        Result_src_E,
  input  logic [31:0] rd1_E,
  input  logic [31:0] rd2_E,
  input  logic [4:0]  Radd_E,
  input  logic [31:0] PC_E,
  input  logic [31:0] extend_out_E,
  input  logic        stall_M,
  output logic        stall_E,
  output logic        valid_M,
  output logic        RegW_enable_M,
  output logic        Mem_Write_M,
  output logic        Result_src_M,
  output logic [31:0] ALU_result_M,
  output logic [31:0] write_data_M,
  output logic [4:0]  Radd_M,
  output logic        redirect,
  output logic [31:0] redirect_PC
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  logic [XLEN-1:0]  op_b;
  logic [XLEN-1:0]  alu_res;
  logic [XLEN-1:0]  link_addr;
  logic [XLEN-1:0]  target;
  logic [CNT_W-1:0] squash_cnt;
  logic             live;
  logic             taken;
  logic             alu_zero;

  assign op_b = ALU_src_E ? extend_out_E : rd2_E;

  // 32-bit ALU; carries and overflow are dropped
  always_comb begin
    alu_res = '0;
    case (ALU_control_E)
      OP_ADD:  alu_res = rd1_E + op_b;
      OP_SUB:  alu_res = rd1_E - op_b;
      OP_AND:  alu_res = rd1_E & op_b;
      OP_OR:   alu_res = rd1_E | op_b;
      OP_XOR:  alu_res = rd1_E ^ op_b;
      OP_SLL:  alu_res = rd1_E << op_b[4:0];
      OP_SRL:  alu_res = rd1_E >> op_b[4:0];
      OP_SRA:  alu_res = $unsigned($signed(rd1_E) >>> op_b[4:0]);
      OP_SLT:  alu_res = ($signed(rd1_E) < $signed(op_b)) ? XLEN'(1) : '0;
      OP_SLTU: alu_res = (rd1_E < op_b) ? XLEN'(1) : '0;
      default: alu_res = '0;
    endcase
  end

  assign alu_zero  = (alu_res == '0);
  assign link_addr = PC_E + XLEN'(4);
  assign target    = PC_E + extend_out_E;

  // A slot is live only when real and not inside the post-redirect shadow
  assign live  = valid_E & (squash_cnt == '0);
  assign taken = live & (Jump_E | (Branch_E & alu_zero));

  assign stall_E = stall_M;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_M       <= 1'b0;
      RegW_enable_M <= 1'b0;
      Mem_Write_M   <= 1'b0;
      Result_src_M  <= 1'b0;
      ALU_result_M  <= '0;
      write_data_M  <= '0;
      Radd_M        <= '0;
    end else if (!stall_M) begin
      valid_M       <= live;
      RegW_enable_M <= live & RegW_enable_E;
      Mem_Write_M   <= live & Mem_Write_E;
      Result_src_M  <= Result_src_E;
      ALU_result_M  <= Jump_E ? link_addr : alu_res;
      write_data_M  <= rd2_E;
      Radd_M        <= Radd_E;
    end
  end

  // Redirect pulse and squash shadow; a load only happens with the counter at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      redirect_PC <= '0;
      squash_cnt  <= '0;
    end else if (!stall_M) begin
      if (taken) begin
        redirect    <= 1'b1;
        redirect_PC <= target;
        squash_cnt  <= CNT_W'(SQUASH_CYCLES);
      end else begin
        redirect <= 1'b0;
        if (squash_cnt != '0) begin
          squash_cnt <= squash_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU sweep, branch/jump redirect, squash, stall, reset.
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_E, Jump_E, Branch_E, RegW_enable_E, ALU_src_E;
  logic [3:0]  ALU_control_E;
  logic        Mem_Write_E, Result_src_E;
  logic [31:0] rd1_E, rd2_E, PC_E, extend_out_E;
  logic [4:0]  Radd_E;
  logic        stall_M;
  logic        stall_E, valid_M, RegW_enable_M, Mem_Write_M, Result_src_M;
  logic [31:0] ALU_result_M, write_data_M, redirect_PC;
  logic [4:0]  Radd_M;
  logic        redirect;

  int total;
  int bad;

  ex_stage #(.SQUASH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_E(valid_E), .Jump_E(Jump_E), .Branch_E(Branch_E),
    .RegW_enable_E(RegW_enable_E), .ALU_src_E(ALU_src_E),
    .ALU_control_E(ALU_control_E), .Mem_Write_E(Mem_Write_E),
    .Result_src_E(Result_src_E), .rd1_E(rd1_E), .rd2_E(rd2_E),
    .Radd_E(Radd_E), .PC_E(PC_E), .extend_out_E(extend_out_E),
    .stall_M(stall_M), .stall_E(stall_E), .valid_M(valid_M),
    .RegW_enable_M(RegW_enable_M), .Mem_Write_M(Mem_Write_M),
    .Result_src_M(Result_src_M), .ALU_result_M(ALU_result_M),
    .write_data_M(write_data_M), .Radd_M(Radd_M),
    .redirect(redirect), .redirect_PC(redirect_PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic v, input logic j, input logic b, input logic rw,
                       input logic src, input logic [3:0] ctl, input logic mw,
                       input logic [31:0] a, input logic [31:0] bb, input logic [4:0] rad,
                       input logic [31:0] pc, input logic [31:0] imm);
    valid_E = v; Jump_E = j; Branch_E = b; RegW_enable_E = rw; ALU_src_E = src;
    ALU_control_E = ctl; Mem_Write_E = mw; Result_src_E = 1'b0;
    rd1_E = a; rd2_E = bb; Radd_E = rad; PC_E = pc; extend_out_E = imm;
  endtask

  task automatic plain(input logic [4:0] rad);
    instr(1, 0, 0, 1, 0, 4'b0000, 0, 32'd1, 32'd2, rad, 32'h200, 32'h0);
  endtask

  logic [3:0]  ops  [11];
  logic [31:0] exps [11];

  initial begin
    total = 0;
    bad   = 0;
    ops  = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
             4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1111};
    exps = '{32'hFFFFFFF4, 32'hFFFFFFEC, 32'h00000000, 32'hFFFFFFF4, 32'hFFFFFFF4,
             32'hFFFFFF00, 32'h0FFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000,
             32'h00000000};
    rst_n   = 1'b0;
    stall_M = 1'b0;
    instr(0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    #1;
    check("rst_valid", 32'(valid_M), 32'd0);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_alu", ALU_result_M, 32'd0);
    #12;
    rst_n = 1'b1;
    step();

    // ALU sweep with register operand B
    for (int i = 0; i < 11; i++) begin
      instr(1, 0, 0, 1, 0, ops[i], 0, 32'hFFFFFFF0, 32'h4, 5'd3, 32'h40, 32'h0);
      step();
      check($sformatf("alu_op%0d", i), ALU_result_M, exps[i]);
      check($sformatf("alu_v%0d", i), 32'(valid_M), 32'd1);
    end
    check("alu_redirect", 32'(redirect), 32'd0);

    // Immediate operand and store path
    instr(1, 0, 0, 0, 1, 4'b0000, 1, 32'd10, 32'hDEADBEEF, 5'd7, 32'h44, 32'd3);
    step();
    check("imm_add", ALU_result_M, 32'd13);
    check("store_mw", 32'(Mem_Write_M), 32'd1);
    check("store_wd", write_data_M, 32'hDEADBEEF);
    check("store_rw", 32'(RegW_enable_M), 32'd0);

    // Taken branch then two squashed slots
    instr(1, 0, 1, 0, 0, 4'b0001, 0, 32'd5, 32'd5, 5'd0, 32'h100, 32'h20);
    step();
    check("br_redirect", 32'(redirect), 32'd1);
    check("br_target", redirect_PC, 32'h120);
    check("br_valid", 32'(valid_M), 32'd1);
    check("br_rw", 32'(RegW_enable_M), 32'd0);
    plain(5'd9);
    step();
    check("sq1_redirect", 32'(redirect), 32'd0);
    check("sq1_valid", 32'(valid_M), 32'd0);
    check("sq1_rw", 32'(RegW_enable_M), 32'd0);
    step();
    check("sq2_valid", 32'(valid_M), 32'd0);
    check("sq2_rw", 32'(RegW_enable_M), 32'd0);
    step();
    check("post_valid", 32'(valid_M), 32'd1);
    check("post_rw", 32'(RegW_enable_M), 32'd1);

    // Not-taken branch
    instr(1, 0, 1, 0, 0, 4'b0001, 0, 32'd5, 32'd6, 5'd0, 32'h180, 32'h20);
    step();
    check("nt_redirect", 32'(redirect), 32'd0);
    check("nt_valid", 32'(valid_M), 32'd1);
    plain(5'd4);
    step();
    check("nt_next_valid", 32'(valid_M), 32'd1);
    check("nt_next_rw", 32'(RegW_enable_M), 32'd1);

    // Jump with link wrap, then stall during the squash shadow
    instr(1, 1, 0, 1, 0, 4'b0000, 0, 32'd0, 32'd0, 5'd1, 32'hFFFFFFFC, 32'd8);
    step();
    check("j_link", ALU_result_M, 32'h0);
    check("j_target", redirect_PC, 32'h4);
    check("j_rw", 32'(RegW_enable_M), 32'd1);
    check("j_radd", 32'(Radd_M), 32'd1);
    check("j_redirect", 32'(redirect), 32'd1);
    plain(5'd12);
    stall_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_stall_e", 32'(stall_E), 32'd1);
      check("st_redirect", 32'(redirect), 32'd1);
      check("st_valid", 32'(valid_M), 32'd1);
      check("st_radd", 32'(Radd_M), 32'd1);
    end
    stall_M = 1'b0;
    #1;
    check("st_release_e", 32'(stall_E), 32'd0);
    step();
    check("st_sq1_valid", 32'(valid_M), 32'd0);
    check("st_sq1_redirect", 32'(redirect), 32'd0);
    step();
    check("st_sq2_valid", 32'(valid_M), 32'd0);
    step();
    check("st_flow_valid", 32'(valid_M), 32'd1);
    check("st_flow_radd", 32'(Radd_M), 32'd12);

    // Bubble with stray control bits
    instr(0, 1, 1, 1, 0, 4'b0000, 1, 32'd0, 32'd0, 5'd2, 32'h300, 32'h10);
    step();
    check("bub_valid", 32'(valid_M), 32'd0);
    check("bub_rw", 32'(RegW_enable_M), 32'd0);
    check("bub_mw", 32'(Mem_Write_M), 32'd0);
    check("bub_redirect", 32'(redirect), 32'd0);

    // Jump and branch together behave as jump (branch condition false)
    instr(1, 1, 1, 1, 0, 4'b0001, 0, 32'd1, 32'd2, 5'd1, 32'h400, 32'h40);
    step();
    check("jb_redirect", 32'(redirect), 32'd1);
    check("jb_target", redirect_PC, 32'h440);
    check("jb_link", ALU_result_M, 32'h404);

    // Asynchronous reset mid-stream with valid_M and redirect high
    plain(5'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(valid_M), 32'd0);
    check("ar_redirect", 32'(redirect), 32'd0);
    check("ar_target", redirect_PC, 32'd0);
    check("ar_alu", ALU_result_M, 32'd0);
    check("ar_radd", 32'(Radd_M), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_after_valid", 32'(valid_M), 32'd1);
    check("ar_after_rw", 32'(RegW_enable_M), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that sits directly downstream of the ID/EX pipeline register and consumes its *_E outputs.
- Performs the ALU operation, resolves branches and jumps, and registers the results into the EX/MEM boundary.
- Issues a one-cycle PC redirect on a taken branch or jump, then squashes the next SQUASH_CYCLES wrong-path slots.
- Propagates downstream stall upstream.

Parameters:
SQUASH_CYCLES, 2, number of accepted slots after a redirect that are converted to bubbles (1..7)

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
valid_E  in  1  ID/EX slot holds a real instruction
Jump_E  in  1  unconditional jump
Branch_E  in  1  conditional branch; taken when ALU result == 0
RegW_enable_E  in  1  register write enable
ALU_src_E  in  1  0: operand B = rd2_E; 1: operand B = extend_out_E
ALU_control_E  in  4  ALU opcode
Mem_Write_E  in  1  store
Result_src_E  in  1  0: ALU result written back; 1: load data written back
rd1_E  in  32  operand A
rd2_E  in  32  register source 2, also the store data
Radd_E  in  5  destination register
PC_E  in  32  instruction PC
extend_out_E  in  32  sign-extended immediate
stall_M  in  1  downstream hold
stall_E  out  1  upstream hold; equal to stall_M (combinational)
valid_M  out  1  EX/MEM slot valid
RegW_enable_M  out  1  registered, gated by slot validity
Mem_Write_M  out  1  registered, gated by slot validity
Result_src_M  out  1  registered
ALU_result_M  out  32  ALU result, or PC_E+4 for a jump
write_data_M  out  32  registered rd2_E
Radd_M  out  5  registered destination register
redirect  out  1  one-cycle pulse: fetch must load redirect_PC
redirect_PC  out  32  PC_E + extend_out_E of the taken instruction

Behaviour:
- Reset (rst_n=0, asynchronous): every output register = 0, squash counter = 0. Reset mid-operation discards in-flight state immediately; there is no recovery of the slot.
- ALU, combinational, 32-bit, overflow discarded. Operand B = ALU_src_E ? extend_out_E : rd2_E. Shifts use B[4:0].
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL
  - 0110 SRL
  - 0111 SRA
  - 1000 SLT (signed)
  - 1001 SLTU
  - all other codes: result 0
- Accept edge: a rising clk with stall_M=0. With stall_M=1, every *_M output, redirect, redirect_PC and the squash counter hold their values.
- live = valid_E AND (squash counter == 0).
- On each accept edge:
  - valid_M <= live.
  - RegW_enable_M <= live & RegW_enable_E.
  - Mem_Write_M <= live & Mem_Write_E.
  - Data fields are captured unconditionally.
  - ALU_result_M <= Jump_E ? PC_E+4 : ALU result.
- taken = live & (Jump_E | (Branch_E & ALU result==0)).
- On an accept edge with taken=1: redirect <= 1, redirect_PC <= PC_E+extend_out_E (wraps mod 2^32), squash counter <= SQUASH_CYCLES.
  - The taken instruction itself proceeds: a jump writes the link register; a branch normally has RegW_enable=0.
- On an accept edge with taken=0: redirect <= 0. If the counter is >0, it decrements by 1.
- Latency: one accept edge from input to *_M outputs. redirect is asserted in the cycle after the taken instruction is accepted and lasts exactly one cycle unless held by a stall.
- A squashed slot can never redirect. Counter loading only occurs when the counter is 0, so there is no overlap case.
- Jump_E and Branch_E both set: treated as a jump.
- valid_E=0 with stray control bits: the slot becomes a bubble; no write, no store, no redirect.

Test Plan:
- Reset: assert rst_n=0 mid-stream with valid_M=1 and redirect=1 -> all outputs 0 asynchronously, before the next clk edge.
- ALU sweep: rd1=0xFFFFFFF0, rd2=0x4, ALU_src=0, each opcode -> ADD 0xFFFFFFF4, SUB 0xFFFFFFEC, SRA 0xFFFFFFFF, SRL 0x0FFFFFFF, SLT 1, SLTU 0, code 1111 -> 0.
- Taken branch: PC_E=0x100, Branch_E=1, SUB, rd1=rd2=5, imm=0x20, SQUASH_CYCLES=2 -> next cycle redirect=1 with redirect_PC=0x120. The following 2 valid inputs with RegW=1 yield valid_M=0 and RegW_enable_M=0. The 3rd valid input passes.
- Not-taken branch: rd1=5, rd2=6 -> redirect stays 0, no squash, next instruction passes.
- Jump link: PC_E=0xFFFFFFFC, Jump_E=1, imm=8, Radd=1 -> ALU_result_M=0x00000000 (wrap), redirect_PC=0x00000004, RegW_enable_M=1.
- Stall during squash: after redirect, hold stall_M=1 for 3 cycles -> stall_E=1, outputs and redirect held, counter stays 2. Release -> 2 bubbles, then normal flow.
